// File: rtl/wb_pkg.sv
// Shared Wishbone initiator types: FSM state encoding, default bus widths and the request bundle.
package wb_pkg;

    localparam int WB_AW = 30;
    localparam int WB_DW = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQUEST  = 2'd1,
        WAIT_ACK = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic                 we;
        logic [WB_AW-1:0]     addr;
        logic [WB_DW-1:0]     data;
        logic [WB_DW/8-1:0]   sel;
    } wb_req_t;

endpackage

// File: rtl/wb_simple_master.sv
// Single-outstanding Wishbone B4 pipelined initiator: one valid/ready command in, one response pulse out.
// Optional bus watchdog compiled in with WB_SIMPLE_MASTER_TIMEOUT_EN.
module wb_simple_master
    import wb_pkg::*;
#(
    parameter int AW             = WB_AW,
    parameter int DW             = WB_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_we,
    input  logic [AW-1:0]   i_req_addr,
    input  logic [DW-1:0]   i_req_data,
    input  logic [DW/8-1:0] i_req_sel,
    output logic            o_rsp_valid,
    output logic [DW-1:0]   o_rsp_data,
    output logic            o_rsp_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [AW-1:0]   o_wb_addr,
    output logic [DW-1:0]   o_wb_data,
    output logic [DW/8-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic            i_wb_err,
    input  logic [DW-1:0]   i_wb_data
);

    wb_state_t state;
    logic      timeout;

    assign o_req_ready = (state == IDLE);

`ifdef WB_SIMPLE_MASTER_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] to_cnt;

    // Held at zero while idle, so it restarts from zero on every accepted command.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            to_cnt <= '0;
        else if (state == IDLE)
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    // Fires on the edge where the count would reach the limit.
    assign timeout = (state != IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the watchdog the limit is irrelevant and the bus waits forever.
    assign timeout = 1'b0 && (TIMEOUT_CYCLES < 2);
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_rsp_valid <= 1'b0;
            o_rsp_err   <= 1'b0;
            o_rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= i_req_we;
                        o_wb_addr <= i_req_addr;
                        o_wb_data <= i_req_data;
                        o_wb_sel  <= i_req_sel;
                        state     <= REQUEST;
                    end
                end
                REQUEST: begin
                    // Slave ack/err while stb is still up is a protocol violation and ignored.
                    if (timeout) begin
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        state       <= IDLE;
                    end else if (!i_wb_stall) begin
                        o_wb_stb <= 1'b0;
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (i_wb_err) begin
                        o_wb_cyc    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        state       <= IDLE;
                    end else if (i_wb_ack) begin
                        o_wb_cyc    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_data  <= o_wb_we ? '0 : i_wb_data;
                        state       <= IDLE;
                    end else if (timeout) begin
                        o_wb_cyc    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    o_wb_cyc <= 1'b0;
                    o_wb_stb <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_simple_master.sv
// Directed bench for wb_simple_master: transaction-level model, per-cycle compare, scripted slave.
module tb_wb_simple_master;

    localparam int AW    = 30;
    localparam int DW    = 32;
    localparam int SW    = DW / 8;
    localparam int TO    = 8;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int              acc;
        int              s;
        int              d;
        int              rsp;
        int              emode;
        bit              noack;
        logic            we;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [SW-1:0]   sel;
        logic [DW-1:0]   rdata;
        logic [DW-1:0]   exp_data;
        logic            exp_err;
    } txn_t;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_req_valid = 1'b0;
    logic            o_req_ready;
    logic            i_req_we = 1'b0;
    logic [AW-1:0]   i_req_addr = '0;
    logic [DW-1:0]   i_req_data = '0;
    logic [SW-1:0]   i_req_sel = '0;
    logic            o_rsp_valid;
    logic [DW-1:0]   o_rsp_data;
    logic            o_rsp_err;
    logic            o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0]   o_wb_addr;
    logic [DW-1:0]   o_wb_data;
    logic [SW-1:0]   o_wb_sel;
    logic            i_wb_ack = 1'b0, i_wb_stall = 1'b0, i_wb_err = 1'b0;
    logic [DW-1:0]   i_wb_data = '0;

    txn_t q[$];
    int   cyc_n = 0;
    int   n_chk = 0, n_err = 0;
    int   rsp_cnt = 0, last_rsp_cycle = 0;
    logic [DW-1:0] last_rsp_data = '0;
    logic last_rsp_err = 1'b0;
    int   stb_run = 0, last_stb_len = 0;
    int   cyc_run = 0, last_cyc_len = 0, low_run = 0, last_gap = 0;
    bit   ovr_ack = 1'b0;

    wb_simple_master #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_data(i_req_data), .i_req_sel(i_req_sel),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data)
    );

    initial forever #5 i_clk = ~i_clk;
    initial forever begin @(posedge i_clk); cyc_n++; end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc_n, act, exp);
        end
    endtask

    // One command; s = stall cycles, d = ack delay, emode 0 ack / 1 err / 2 both.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] sel, input int s, input int d, input int emode,
                        input bit noack, input logic [DW-1:0] rdata, output int acc);
        txn_t t;
        int   budget;
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_data = data; i_req_sel = sel;
        budget = 0;
        while (!o_req_ready && budget < 200) begin @(negedge i_clk); budget++; end
        chk("accept", 64'(o_req_ready), 64'(1));
        acc = cyc_n;
        t.acc = acc; t.s = s; t.d = d; t.emode = emode; t.noack = noack;
        t.we = we; t.addr = addr; t.data = data; t.sel = sel; t.rdata = rdata;
        t.exp_err  = (emode != 0) || noack;
        t.exp_data = (we || t.exp_err) ? '0 : rdata;
`ifdef WB_SIMPLE_MASTER_TIMEOUT_EN
        t.rsp = noack ? acc + 1 + TO : acc + 3 + s + d;
`else
        t.rsp = noack ? NEVER : acc + 3 + s + d;
`endif
        q.push_back(t);
        @(posedge i_clk); #1;
        i_req_valid = 1'b0; i_req_we = ~we; i_req_addr = '1; i_req_data = 32'h0BAD0BAD; i_req_sel = '0;
    endtask

    task automatic wait_rsp(input int n);
        int b = 0;
        while (rsp_cnt < n && b < 200) begin @(negedge i_clk); b++; end
        chk("rsp_arrived", 64'(rsp_cnt >= n), 64'(1));
    endtask

    // Scripted slave driven from the head of the model queue.
    initial begin
        int st = 0, wt = 0;
        forever begin
            @(negedge i_clk);
            i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_stall = 1'b0; i_wb_data = 32'hBAD0BAD0;
            if (o_wb_cyc && q.size() > 0) begin
                if (o_wb_stb) begin
                    i_wb_stall = (st < q[0].s);
                    st++;
                end else begin
                    if (!q[0].noack && wt == q[0].d) begin
                        i_wb_ack  = (q[0].emode != 1);
                        i_wb_err  = (q[0].emode != 0);
                        i_wb_data = q[0].rdata;
                    end
                    wt++;
                end
            end else begin
                st = 0; wt = 0;
            end
            i_wb_ack = i_wb_ack | ovr_ack;
        end
    end

    // Per-cycle compare against the transaction model.
    initial begin
        txn_t h;
        bit have, e_cyc, e_stb, e_rsp;
        forever begin
            @(negedge i_clk);
            if (i_reset) continue;
            have = (q.size() > 0);
            if (have) h = q[0];
            e_cyc = have && cyc_n >= h.acc + 1 && cyc_n < h.rsp;
            e_stb = e_cyc && cyc_n <= h.acc + 1 + h.s;
            e_rsp = have && cyc_n == h.rsp;
            chk("cyc", 64'(o_wb_cyc), 64'(e_cyc));
            chk("stb", 64'(o_wb_stb), 64'(e_stb));
            chk("rsp_valid", 64'(o_rsp_valid), 64'(e_rsp));
            chk("req_ready", 64'(o_req_ready), 64'(!e_cyc));
            if (e_stb) begin
                chk("addr", 64'(o_wb_addr), 64'(h.addr));
                chk("we", 64'(o_wb_we), 64'(h.we));
                chk("wdata", 64'(o_wb_data), 64'(h.data));
                chk("sel", 64'(o_wb_sel), 64'(h.sel));
            end
            if (e_rsp) begin
                chk("rsp_data", 64'(o_rsp_data), 64'(h.exp_data));
                chk("rsp_err", 64'(o_rsp_err), 64'(h.exp_err));
                void'(q.pop_front());
            end
            if (o_rsp_valid) begin
                rsp_cnt++; last_rsp_cycle = cyc_n; last_rsp_data = o_rsp_data; last_rsp_err = o_rsp_err;
            end
            if (o_wb_stb) stb_run++;
            else if (stb_run > 0) begin last_stb_len = stb_run; stb_run = 0; end
            if (o_wb_cyc) begin
                if (low_run > 0) last_gap = low_run;
                low_run = 0; cyc_run++;
            end else begin
                if (cyc_run > 0) last_cyc_len = cyc_run;
                cyc_run = 0; low_run++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=running want=finished", cyc_n);
        $fatal(1, "bench watchdog");
    end

    initial begin
        int a, b, n0;
        #2;
        chk("rst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("rst_stb", 64'(o_wb_stb), 64'(0));
        chk("rst_rsp", 64'(o_rsp_valid), 64'(0));
        chk("rst_ready", 64'(o_req_ready), 64'(1));
        chk("rst_addr", 64'(o_wb_addr), 64'(0));
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;

        // zero-stall write
        n0 = rsp_cnt;
        send(1'b1, 30'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 32'hCAFEF00D, a);
        wait_rsp(n0 + 1);
        chk("t1_lat", 64'(last_rsp_cycle - a), 64'(3));
        chk("t1_stb_len", 64'(last_stb_len), 64'(1));
        chk("t1_data", 64'(last_rsp_data), 64'(0));
        chk("t1_err", 64'(last_rsp_err), 64'(0));

        // read with 3 stall cycles
        n0 = rsp_cnt;
        send(1'b0, 30'h4, 32'h0, 4'hF, 3, 0, 0, 1'b0, 32'h12345678, a);
        wait_rsp(n0 + 1);
        chk("t2_lat", 64'(last_rsp_cycle - a), 64'(6));
        chk("t2_stb_len", 64'(last_stb_len), 64'(4));
        chk("t2_data", 64'(last_rsp_data), 64'h12345678);
        chk("t2_err", 64'(last_rsp_err), 64'(0));

        // bus error after one wait cycle
        n0 = rsp_cnt;
        send(1'b0, 30'h8, 32'h0, 4'h3, 0, 1, 1, 1'b0, 32'h77777777, a);
        wait_rsp(n0 + 1);
        chk("t3_lat", 64'(last_rsp_cycle - a), 64'(4));
        chk("t3_err", 64'(last_rsp_err), 64'(1));
        chk("t3_data", 64'(last_rsp_data), 64'(0));
        chk("t3_cyc_len", 64'(last_cyc_len), 64'(3));

        // ack and err together
        n0 = rsp_cnt;
        send(1'b0, 30'h9, 32'h0, 4'hF, 0, 0, 2, 1'b0, 32'h55555555, a);
        wait_rsp(n0 + 1);
        chk("t4_err", 64'(last_rsp_err), 64'(1));
        chk("t4_data", 64'(last_rsp_data), 64'(0));

        // back-to-back: second command waits and is taken in the first response cycle
        n0 = rsp_cnt;
        send(1'b1, 30'h20, 32'h00000011, 4'h3, 0, 0, 0, 1'b0, 32'h0, a);
        send(1'b0, 30'h21, 32'h0, 4'hF, 1, 1, 0, 1'b0, 32'hA5A5A5A5, b);
        wait_rsp(n0 + 2);
        chk("b2b_accept", 64'(b - a), 64'(3));
        chk("b2b_gap", 64'(last_gap), 64'(1));
        chk("b2b_lat", 64'(last_rsp_cycle - b), 64'(5));
        chk("b2b_data", 64'(last_rsp_data), 64'hA5A5A5A5);

        // async reset mid WAIT_ACK, then a stray ack
        n0 = rsp_cnt;
        send(1'b0, 30'h30, 32'h0, 4'hF, 0, 0, 0, 1'b1, 32'h0, a);
        repeat (2) @(posedge i_clk);
        #2;
        chk("pre_rst_cyc", 64'(o_wb_cyc), 64'(1));
        chk("pre_rst_stb", 64'(o_wb_stb), 64'(0));
        i_reset = 1'b1;
        q.delete();
        #1;
        chk("arst_cyc", 64'(o_wb_cyc), 64'(0));
        chk("arst_stb", 64'(o_wb_stb), 64'(0));
        chk("arst_rsp", 64'(o_rsp_valid), 64'(0));
        chk("arst_ready", 64'(o_req_ready), 64'(1));
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 1'b0;
        ovr_ack = 1'b1;
        repeat (3) @(negedge i_clk);
        ovr_ack = 1'b0;
        repeat (3) @(negedge i_clk);
        chk("arst_no_rsp", 64'(rsp_cnt), 64'(n0));

        // slave never answers
        n0 = rsp_cnt;
        send(1'b1, 30'h3F, 32'h01020304, 4'hF, 0, 0, 0, 1'b1, 32'h0, a);
`ifdef WB_SIMPLE_MASTER_TIMEOUT_EN
        wait_rsp(n0 + 1);
        chk("to_lat", 64'(last_rsp_cycle - a), 64'(9));
        chk("to_cyc_len", 64'(last_cyc_len), 64'(8));
        chk("to_err", 64'(last_rsp_err), 64'(1));
        chk("to_data", 64'(last_rsp_data), 64'(0));
`else
        repeat (110) @(negedge i_clk);
        chk("hang_cyc", 64'(o_wb_cyc), 64'(1));
        chk("hang_span", 64'(cyc_n - a >= 100), 64'(1));
        chk("hang_no_rsp", 64'(rsp_cnt), 64'(n0));
        @(posedge i_clk); #2;
        i_reset = 1'b1;
        q.delete();
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 1'b0;
`endif

        // recovery read
        n0 = rsp_cnt;
        send(1'b0, 30'h7, 32'h0, 4'hF, 0, 2, 0, 1'b0, 32'h0F0F0F0F, a);
        wait_rsp(n0 + 1);
        chk("t8_lat", 64'(last_rsp_cycle - a), 64'(5));
        chk("t8_data", 64'(last_rsp_data), 64'h0F0F0F0F);

        repeat (3) @(negedge i_clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
